// File: rtl/fan_pkg.sv
// Shared definitions for the fan add node: FP32 width, lane op codes and special constants.
package fan_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    MODE_A   = 2'b00,
    MODE_B   = 2'b01,
    MODE_ADD = 2'b10,
    MODE_ACC = 2'b11
  } mode_e;

endpackage

// File: rtl/fan_add_lane.sv
// One FP32 lane: op select, A+B and acc+A adders, result register and running accumulator.
module fan_add_lane
  import fan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              cap_i,
  input  logic [FP32_W-1:0] a_i,
  input  logic [FP32_W-1:0] b_i,
  input  mode_e             mode_i,
  input  logic              clr_i,
  output logic [FP32_W-1:0] res_o
);

  logic [FP32_W-1:0] acc_q, res_q, res_d;
  logic [FP32_W-1:0] acc_src, sum_ab, sum_acc;

  assign acc_src = clr_i ? FP32_POS_ZERO : acc_q;

  fp32adder u_add_ab (
    .a_i   (a_i),
    .b_i   (b_i),
    .sum_o (sum_ab)
  );

  fp32adder u_add_acc (
    .a_i   (acc_src),
    .b_i   (a_i),
    .sum_o (sum_acc)
  );

  always_comb begin
    res_d = a_i;
    unique case (mode_i)
      MODE_A:   res_d = a_i;
      MODE_B:   res_d = b_i;
      MODE_ADD: res_d = sum_ab;
      MODE_ACC: res_d = sum_acc;
      default:  res_d = a_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      acc_q <= FP32_POS_ZERO;
    end else if (en_i) begin
      res_q <= res_d;
      if (cap_i && (mode_i == MODE_ACC)) acc_q <= sum_acc;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/fp32adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even, gradual underflow.
module fp32adder
  import fan_pkg::*;
(
  input  logic [FP32_W-1:0] a_i,
  input  logic [FP32_W-1:0] b_i,
  output logic [FP32_W-1:0] sum_o
);

  logic              a_nan, b_nan, a_inf, b_inf;
  logic [FP32_W-1:0] x, y;
  logic [9:0]        ex, ey, e, ee, d;
  logic [26:0]       mx, my, my_sh, m;
  logic [27:0]       s;
  logic              sub, rup;
  logic [32:0]       rnd;

  assign a_nan = (&a_i[30:23]) & (|a_i[22:0]);
  assign b_nan = (&b_i[30:23]) & (|b_i[22:0]);
  assign a_inf = (&a_i[30:23]) & ~(|a_i[22:0]);
  assign b_inf = (&b_i[30:23]) & ~(|b_i[22:0]);

  always_comb begin
    // x always carries the larger magnitude, so the result sign is x's.
    if (a_i[30:0] >= b_i[30:0]) begin
      x = a_i;
      y = b_i;
    end else begin
      x = b_i;
      y = a_i;
    end
    ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
    mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
    my = {y[30:23] != 8'd0, y[22:0], 3'b000};
    d  = ex - ey;
    if (d >= 10'd27) my_sh = {26'd0, |my};
    else             my_sh = (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
    sub = x[31] ^ y[31];
    s   = sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});
    if (s[27]) begin
      m = {s[27:2], s[1] | s[0]};
      e = ex + 10'd1;
    end else begin
      m = s[26:0];
      e = ex;
    end
    for (int unsigned i = 0; i < 26; i++) begin
      if (!m[26] && (e > 10'd1)) begin
        m = m << 1;
        e = e - 10'd1;
      end
    end
    ee  = m[26] ? e : 10'd0;
    rup = m[2] & (m[3] | m[1] | m[0]);
    // Rounding carry ripples from fraction into exponent (denormal->normal, overflow->next binade).
    rnd = {ee, m[25:3]} + {32'd0, rup};

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] ^ b_i[31]))) sum_o = FP32_QNAN;
    else if (a_inf || b_inf)              sum_o = a_inf ? a_i : b_i;
    else if (s == 28'd0)                  sum_o = {x[31] & y[31], 31'd0};
    else if (rnd[32:23] >= 10'd255)       sum_o = {x[31], 8'hFF, 23'd0};
    else                                  sum_o = {x[31], rnd[30:0]};
  end

endmodule

// File: rtl/fan_add_node.sv
// LANES-wide FP32 add/select stage behind a PIPE-deep, globally stalled valid/ready pipeline.
module fan_add_node
  import fan_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PIPE  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FP32_W*LANES-1:0]   ain,
  input  logic [FP32_W*LANES-1:0]   bin,
  input  logic [2*LANES-1:0]        mode,
  input  logic [LANES-1:0]          acc_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FP32_W*LANES-1:0]   out,
  output logic                      busy
);

  logic [PIPE-1:0]            vld_q, vld_d;
  logic                       advance;
  logic                       cap_v;
  logic [FP32_W*LANES-1:0]    fa, fb;
  logic [2*LANES-1:0]         fm;
  logic [LANES-1:0]           fc;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[PIPE-1];
  assign busy      = |vld_q;

  always_comb begin
    vld_d = vld_q;
    if (advance) begin
      vld_d[0] = in_valid;
      for (int unsigned i = 1; i < PIPE; i++) vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // Stages 1..PIPE-1 only carry operands; the lanes' result registers form stage PIPE.
  if (PIPE > 1) begin : g_ops
    logic [FP32_W*LANES-1:0] a_q [PIPE-1];
    logic [FP32_W*LANES-1:0] b_q [PIPE-1];
    logic [2*LANES-1:0]      m_q [PIPE-1];
    logic [LANES-1:0]        c_q [PIPE-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < PIPE-1; i++) begin
          a_q[i] <= '0;
          b_q[i] <= '0;
          m_q[i] <= '0;
          c_q[i] <= '0;
        end
      end else if (advance) begin
        a_q[0] <= ain;
        b_q[0] <= bin;
        m_q[0] <= mode;
        c_q[0] <= acc_clr;
        for (int unsigned i = 1; i < PIPE-1; i++) begin
          a_q[i] <= a_q[i-1];
          b_q[i] <= b_q[i-1];
          m_q[i] <= m_q[i-1];
          c_q[i] <= c_q[i-1];
        end
      end
    end

    assign fa    = a_q[PIPE-2];
    assign fb    = b_q[PIPE-2];
    assign fm    = m_q[PIPE-2];
    assign fc    = c_q[PIPE-2];
    assign cap_v = vld_q[PIPE-2];
  end else begin : g_direct
    assign fa    = ain;
    assign fb    = bin;
    assign fm    = mode;
    assign fc    = acc_clr;
    assign cap_v = in_valid;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fan_add_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (advance),
      .cap_i  (cap_v),
      .a_i    (fa[FP32_W*l +: FP32_W]),
      .b_i    (fb[FP32_W*l +: FP32_W]),
      .mode_i (mode_e'(fm[2*l +: 2])),
      .clr_i  (fc[l]),
      .res_o  (out[FP32_W*l +: FP32_W])
    );
  end

endmodule

// File: tb/tb_fan_add_node.sv
// Scoreboard bench for fan_add_node: driver queues expected beats, monitor pops on each consumed result.
module tb_fan_add_node;

  localparam int LANES = 4;
  localparam int PIPE  = 2;
  localparam int W     = 32 * LANES;

  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] F6 = 32'h40C0_0000;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   ain, bin, out;
  logic [2*LANES-1:0] mode;
  logic [LANES-1:0]   acc_clr;

  typedef struct {
    logic [W-1:0] exp;
    int unsigned  cyc;
    bit           exact;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          stall_left = 0;
  bit          exact_mode = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fan_add_node #(.LANES(LANES), .PIPE(PIPE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  function automatic logic [W-1:0] ln(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [2*LANES-1:0] md(input logic [1:0] m0, m1, m2, m3);
    return {m3, m2, m1, m0};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, decide acceptance before the rising edge.
  task automatic tick(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*LANES-1:0] m, input logic [LANES-1:0] c,
                      input logic [W-1:0] e, output bit acc);
    @(negedge clk);
    in_valid  = v;
    ain       = a;
    bin       = b;
    mode      = m;
    acc_clr   = c;
    out_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    #1;
    if (out_valid && !out_ready) chk("in_ready_stall", {127'd0, in_ready}, '0);
    acc = v && in_ready && !rst;
    if (acc) sb.push_back('{exp: e, cyc: cyc, exact: exact_mode});
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*LANES-1:0] m, input logic [LANES-1:0] c,
                      input logic [W-1:0] e);
    bit acc;
    int n;
    n = 0;
    do begin
      tick(1'b1, a, b, m, c, e, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, ain, bin, mode, acc_clr, '0, acc);
  endtask

  // Monitor
  logic [W-1:0] hold;
  bit           hold_v = 1'b0;
  exp_t         got;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("out_hold_data", out, hold);
          chk("out_hold_valid", {127'd0, out_valid}, 1);
        end
        hold_v = 1'b0;
        if (out_valid && !out_ready) begin
          hold_v = 1'b1;
          hold   = out;
        end else if (out_valid) begin
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected actual=%h required=no_beat", out);
          end else begin
            got = sb.pop_front();
            chk("out_data", out, got.exp);
            if (got.exact) chk("latency", W'(cyc - got.cyc), W'(PIPE));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; ain = '0; bin = '0; mode = '0; acc_clr = '0; out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("reset_out_valid", {127'd0, out_valid}, '0);
    chk("reset_out", out, '0);
    chk("reset_busy", {127'd0, busy}, '0);

    // Mid-stream reset: ACC beats in flight are dropped and accumulators cleared.
    send(ln(F2, F2, F2, F2), '0, 8'hFF, 4'h0, ln(F2, F2, F2, F2));
    send(ln(F2, F2, F2, F2), '0, 8'hFF, 4'h0, ln(F4, F4, F4, F4));
    send(ln(F2, F2, F2, F2), '0, 8'hFF, 4'h0, ln(F6, F6, F6, F6));
    rst = 1'b1;
    sb.delete();
    idle(2);
    rst = 1'b0;
    chk("rst2_out_valid", {127'd0, out_valid}, '0);
    chk("rst2_out", out, '0);
    chk("rst2_busy", {127'd0, busy}, '0);
    idle(1);
    chk("rst2_no_valid_after", {127'd0, out_valid}, '0);

    // First ACC after reset starts from +0.0.
    send(ln(F1, F1, F1, F1), '0, 8'hFF, 4'h0, ln(F1, F1, F1, F1));
    idle(3);

    // Modes: A, B, A+B, ACC(with clear).
    send(ln(F1, F1, F1, F1), ln(F2, F2, F2, F2), md(2'b00, 2'b01, 2'b10, 2'b11), 4'b1000,
         ln(F1, F2, F3, F1));
    // A+B with cancellation, carry-out and exact zero.
    send(ln(F3, F1, 32'h3FC0_0000, 32'h40A0_0000), ln(32'hBF80_0000, F1, 32'h3F00_0000, 32'hC0A0_0000),
         8'hAA, 4'h0, ln(F2, F2, F2, 32'h0000_0000));
    idle(3);

    // Accumulate on lane0; lane3 acc_clr in mode A must be ignored.
    send(ln(F1, F1, F1, F1), ln(F2, F2, F2, F2), md(2'b11, 2'b01, 2'b00, 2'b00), 4'b1001, ln(F1, F2, F1, F1));
    send(ln(F2, F2, F2, F2), ln(F2, F2, F2, F2), md(2'b11, 2'b01, 2'b00, 2'b00), 4'b1000, ln(F3, F2, F2, F2));
    send(ln(F3, F3, F3, F3), ln(F2, F2, F2, F2), md(2'b11, 2'b01, 2'b00, 2'b00), 4'b1000, ln(F6, F2, F3, F3));
    send(ln(F2, F2, F2, F2), ln(F2, F2, F2, F2), md(2'b11, 2'b01, 2'b00, 2'b00), 4'b1001, ln(F2, F2, F2, F2));
    send(ln(F1, F1, F1, F1), '0, md(2'b00, 2'b00, 2'b00, 2'b11), 4'b0000, ln(F1, F1, F1, F2));
    idle(3);

    // Bubbles: invalid cycles carry the same ACC data but must not count.
    send(ln(F1, F1, F1, F1), '0, 8'hFF, 4'hF, ln(F1, F1, F1, F1));
    idle(1);
    send(ln(F1, F1, F1, F1), '0, 8'hFF, 4'h0, ln(F2, F2, F2, F2));
    idle(1);
    send(ln(F1, F1, F1, F1), '0, 8'hFF, 4'h0, ln(F3, F3, F3, F3));
    idle(1);
    send(ln(F1, F1, F1, F1), '0, 8'hFF, 4'h0, ln(F4, F4, F4, F4));
    idle(3);

    // Backpressure: out_ready low for 3 cycles starting at beat 3.
    begin
      logic [31:0] sums [8];
      sums[0] = F1; sums[1] = F2; sums[2] = F3; sums[3] = F4;
      sums[4] = 32'h40A0_0000; sums[5] = F6; sums[6] = 32'h40E0_0000; sums[7] = 32'h4100_0000;
      exact_mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (i == 2) stall_left = 3;
        send(ln(F1, F1, F1, F1), ln(32'h0, 32'h1111_0000 + i, F1, 32'h3333_0000 + i),
             md(2'b11, 2'b01, 2'b10, 2'b01), (i == 0) ? 4'b0001 : 4'b0000,
             ln(sums[i], 32'h1111_0000 + i, F2, 32'h3333_0000 + i));
      end
      idle(6);
      exact_mode = 1'b1;
    end

    // Full rate: one result per cycle, busy held, then drains PIPE cycles after the last accept.
    for (int i = 0; i < 16; i++) begin
      send(ln(32'hA000_0000 + i, 32'hB000_0000 + i, 32'hC000_0000 + i, 32'hD000_0000 + i), '0,
           8'h00, 4'h0,
           ln(32'hA000_0000 + i, 32'hB000_0000 + i, 32'hC000_0000 + i, 32'hD000_0000 + i));
      if (i > 0) chk("busy_full_rate", {127'd0, busy}, 1);
    end
    idle(PIPE);
    chk("busy_before_drain", {127'd0, busy}, 1);
    idle(1);
    chk("busy_after_drain", {127'd0, busy}, '0);

    idle(4);
    chk("all_delivered", W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
